adc128s022_scanner: RTL
=======================

// Module: adc128s022_scanner
// PURPOSE
// Round-robin SPI scanner for the on-board ADC128S022 8-channel 12-bit ADC.
// Drives ADC_SCLK/ADC_CS_N/ADC_SADDR, samples ADC_SDAT and returns one
// 12-bit result per frame, tagged with its channel.
// Instantiated in de0nano_ports beside adxl345_reader, replacing the ADC tie-offs.
// Results feed user logic through a one-cycle valid strobe.
// PARAMETERS
// CLK_DIV       25     clk cycles per SCLK half-period (50 MHz -> 1 MHz SCLK); >= 2
// CHANNEL_MASK  8'hFF  bit n=1 -> channel n is scanned; 8'h00 is treated as 8'h01
// FRAME_GAP     4      clk cycles cs_n is held high between frames; >= 1
// PORTS
// clk           in   1   system clock (CLOCK_50)
// rst           in   1   synchronous, active-high reset
// enable        in   1   level; 1 = scan continuously, 0 = stop after the current frame
// sclk          out  1   SPI clock to ADC_SCLK, idles high
// cs_n          out  1   chip select to ADC_CS_N, active low
// saddr         out  1   MOSI to ADC_SADDR (next-channel address)
// sdat          in   1   MISO from ADC_SDAT
// busy          out  1   1 while any frame or gap is in progress
// sample_valid  out  1   one-cycle strobe, sample_ch/sample_data are new
// sample_ch     out  3   channel of sample_data
// sample_data   out  12  unsigned conversion result, MSB first off the wire
// BEHAVIOUR
// - Reset values: sclk=1, cs_n=1, saddr=0, busy=0, sample_valid=0, sample_ch=0,
//   sample_data=0, state=IDLE, primed=0, next channel = lowest set mask bit.
// - FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> (SETUP if enable, else IDLE).
// - IDLE: outputs idle. enable=1 -> SETUP, with cs_n=0 on the same edge.
// - SETUP: CLK_DIV cycles, cs_n=0, sclk=1.
// - SHIFT: 16 SCLK periods, bit k=0..15. Each period has two halves:
//   - sclk=0 for CLK_DIV cycles; saddr updates on the falling edge.
//   - sclk=1 for CLK_DIV cycles.
// - saddr = addr[2], addr[1], addr[0] at k=2,3,4; 0 at all other k.
//   addr = channel to be converted in the NEXT frame.
// - sdat is captured on the clk edge that drives sclk 0->1. Bits k=4..15 shift
//   MSB-first into a 12-bit register; bits k=0..3 are ignored (leading zeros).
// - HOLD: CLK_DIV cycles with sclk=1, then cs_n=1 on the exit edge.
// - Frame length, cs_n low to high: 34*CLK_DIV cycles (850 at default).
// - Results: the data in frame N belongs to the address sent in frame N-1.
//   - The first frame after leaving IDLE or reset is a primer: no sample_valid, primed<=1.
//   - Later frames: on the edge where cs_n rises, sample_valid=1 for one cycle,
//     sample_ch = previous frame's addr, sample_data = shift register.
//   - sample_ch/sample_data hold until the next strobe.
// - GAP: FRAME_GAP cycles with cs_n=1, sclk=1.
// - Channel sequencing: addr advances to the next set mask bit above the current
//   one, wrapping 7->0. A single-bit mask repeats that channel.
// - enable is sampled only in IDLE and at the end of GAP. Dropping enable mid-frame
//   completes the frame, strobes its result if primed, then goes to IDLE with primed=0.
// - rst mid-frame: on the next edge, immediate return to reset values. No strobe.
//   The partial frame is abandoned, and the next start begins with a primer.
// - busy=1 in every state except IDLE.
// - Steady-state throughput: one sample per 34*CLK_DIV+FRAME_GAP cycles.
// TESTING
// - Reset, enable=0 for 100 cycles -> sclk=1, cs_n=1, busy=0, sample_valid never 1.
// - ADC model returns 12'hA5C on ch0, CLK_DIV=2, mask 8'h01, enable=1:
//   - first frame: no strobe;
//   - second frame: strobe with ch=0, data=12'hA5C;
//   - cs_n low for exactly 68 cycles per frame.
// - Mask 8'h8A, model returns data = {9'h0,ch}: strobes carry ch 1,3,7,1,3,...;
//   - each strobe's data equals its ch;
//   - saddr bits decoded by the model confirm the one-frame lookahead.
// - enable dropped at bit k=7 of a primed frame -> frame completes, one strobe,
//   then IDLE, busy=0; re-enable -> primer frame with no strobe.
// - rst pulsed at bit k=9 -> next cycle cs_n=1, sclk=1, sample_data=0, no strobe;
//   restart yields a primer then correct data.
// - Model drives sdat=1 during k=0..3 and 12'h000 after -> sample_data=12'h000
//   (leading bits ignored).

Source files
------------

// File: rtl/adc128s022_scanner.sv
// Round-robin SPI scanner for the ADC128S022 8-channel 12-bit ADC.
// Latency: one 12-bit result per frame of 34*CLK_DIV cycles plus FRAME_GAP idle cycles; each result is tagged with its channel.
// Backpressure: none. sample_valid is a one-cycle strobe, and enable only stops scanning at a frame boundary.
//
// Ports:
//   clk, rst      system clock; synchronous active-high reset
//   enable        level; 1 = scan continuously, 0 = stop after the current frame
//   sclk, cs_n    SPI clock (idles high) and chip select (active low)
//   saddr, sdat   MOSI (address of the next channel) and MISO (conversion data)
//   busy          high in every state except IDLE
//   sample_valid  one-cycle strobe; sample_ch/sample_data hold until the next strobe
module adc128s022_scanner #(
  parameter int         CLK_DIV      = 25,
  parameter logic [7:0] CHANNEL_MASK = 8'hFF,
  parameter int         FRAME_GAP    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        sclk,
  output logic        cs_n,
  output logic        saddr,
  input  logic        sdat,
  output logic        busy,
  output logic        sample_valid,
  output logic [2:0]  sample_ch,
  output logic [11:0] sample_data
);

  // An empty mask would leave nothing to scan, so it falls back to channel 0.
  localparam logic [7:0] MASK = (CHANNEL_MASK == 8'h00) ? 8'h01 : CHANNEL_MASK;

  localparam int CNT_MAX = (CLK_DIV > FRAME_GAP) ? CLK_DIV : FRAME_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(FRAME_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  // Lowest set bit of the mask: the channel sequence starts here after reset.
  function automatic logic [2:0] first_ch();
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (MASK[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Next set mask bit above cur, wrapping 7->0. The loop runs downwards so
  // the nearest candidate wins. A single-bit mask returns cur itself.
  function automatic logic [2:0] next_ch(input logic [2:0] cur);
    logic [2:0] r;
    logic [2:0] c;
    r = cur;
    for (int i = 7; i >= 1; i--) begin
      c = cur + 3'(i);
      if (MASK[c]) r = c;
    end
    return r;
  endfunction

  // The ADC reads its next-channel address from bits 2..4 of the frame, MSB first.
  function automatic logic addr_bit(input logic [3:0] k, input logic [2:0] a);
    case (k)
      4'd2:    return a[2];
      4'd3:    return a[1];
      4'd4:    return a[0];
      default: return 1'b0;
    endcase
  endfunction

  localparam logic [2:0] FIRST_CH = first_ch();

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_k;
  logic [11:0]   shreg;
  logic [2:0]    addr;       // address sent in the current frame
  logic [2:0]    prev_addr;  // address sent in the previous frame; its data arrives now
  logic          primed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_k        <= '0;
      shreg        <= '0;
      addr         <= FIRST_CH;
      prev_addr    <= '0;
      primed       <= 1'b0;
      sclk         <= 1'b1;
      cs_n         <= 1'b1;
      saddr        <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= SETUP;
            cs_n  <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end

        SETUP: begin
          if (cnt == DIV_LAST) begin
            state <= SHIFT;
            cnt   <= '0;
            bit_k <= '0;
            sclk  <= 1'b0;
            saddr <= addr_bit(4'd0, addr);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // sclk doubles as the half-period flag: 0 = low half, 1 = high half.
        SHIFT: begin
          if (cnt != DIV_LAST) begin
            cnt <= cnt + CW'(1);
          end else begin
            cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
              // The first four bits off the wire are leading zeros.
              if (bit_k >= 4'd4) shreg <= {shreg[10:0], sdat};
            end else if (bit_k == 4'd15) begin
              state <= HOLD;
            end else begin
              bit_k <= bit_k + 4'd1;
              sclk  <= 1'b0;
              saddr <= addr_bit(bit_k + 4'd1, addr);
            end
          end
        end

        HOLD: begin
          if (cnt == DIV_LAST) begin
            state     <= GAP;
            cnt       <= '0;
            cs_n      <= 1'b1;
            primed    <= 1'b1;
            // The data in this frame was converted from the address sent last frame.
            if (primed) begin
              sample_valid <= 1'b1;
              sample_ch    <= prev_addr;
              sample_data  <= shreg;
            end
            prev_addr <= addr;
            addr      <= next_ch(addr);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (enable) begin
              state <= SETUP;
              cs_n  <= 1'b0;
            end else begin
              state  <= IDLE;
              busy   <= 1'b0;
              primed <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
